// File: rtl/button_event_decoder.sv
// Turns a debounced, synchronous button level into registered one-cycle gesture pulses:
// press, release, single click, double click and long press, plus a registered held level.
module button_event_decoder #(
  parameter int unsigned c_LONG_PRESS_LIMIT = 6000000,
  parameter int unsigned c_DOUBLE_GAP_LIMIT = 3000000
) (
  input  logic CLK,
  input  logic i_Rst_L,
  input  logic i_BTN,
  output logic o_Press,
  output logic o_Release,
  output logic o_Single_Click,
  output logic o_Double_Click,
  output logic o_Long_Press,
  output logic o_Held
);

  typedef enum logic [2:0] {
    StIdle,
    StPressed1,
    StWaitGap,
    StPressed2,
    StLongHeld
  } state_e;

  // Counter reads limit-1 on the edge that is exactly "limit" cycles after the state was entered.
  localparam logic [23:0] LongLast = 24'(c_LONG_PRESS_LIMIT - 1);
  localparam logic [23:0] GapLast  = 24'(c_DOUBLE_GAP_LIMIT - 1);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        btn_q;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        single_q, single_d;
  logic        double_q, double_d;
  logic        long_q, long_d;

  logic rise, fall, long_hit, gap_hit;

  assign rise     = i_BTN & ~btn_q;
  assign fall     = ~i_BTN & btn_q;
  assign long_hit = (cnt_q == LongLast);
  assign gap_hit  = (cnt_q == GapLast);

  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= i_BTN;
      press_q   <= press_d;
      release_q <= release_d;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (rise) state_d = StPressed1;
      StPressed1: begin
        if (fall)          state_d = StWaitGap;
        else if (long_hit) state_d = StLongHeld;
      end
      // A press landing on the timeout edge still counts as the second click.
      StWaitGap:  begin
        if (rise)         state_d = StPressed2;
        else if (gap_hit) state_d = StIdle;
      end
      StPressed2: begin
        if (fall)          state_d = StIdle;
        else if (long_hit) state_d = StLongHeld;
      end
      StLongHeld: if (fall) state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StPressed1 || state_q == StWaitGap || state_q == StPressed2) begin
      cnt_d = cnt_q + 24'd1;
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    press_d   = rise;
    release_d = fall;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      StPressed1: long_d   = ~fall & long_hit;
      StWaitGap:  single_d = ~rise & gap_hit;
      StPressed2: begin
        double_d = fall;
        long_d   = ~fall & long_hit;
      end
      default: ;
    endcase
  end

  assign o_Press        = press_q;
  assign o_Release      = release_q;
  assign o_Single_Click = single_q;
  assign o_Double_Click = double_q;
  assign o_Long_Press   = long_q;
  assign o_Held         = btn_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: a timestamp-based gesture model checks every output on every cycle,
// with directed gesture scenarios pinning exact pulse timings and random button traffic.
module tb_button_event_decoder;

  localparam int unsigned L = 20;
  localparam int unsigned G = 10;

  logic CLK = 1'b0;
  logic i_Rst_L = 1'b1;
  logic i_BTN = 1'b0;
  logic o_Press, o_Release, o_Single_Click, o_Double_Click, o_Long_Press, o_Held;

  button_event_decoder #(
    .c_LONG_PRESS_LIMIT(L),
    .c_DOUBLE_GAP_LIMIT(G)
  ) dut (
    .CLK           (CLK),
    .i_Rst_L       (i_Rst_L),
    .i_BTN         (i_BTN),
    .o_Press       (o_Press),
    .o_Release     (o_Release),
    .o_Single_Click(o_Single_Click),
    .o_Double_Click(o_Double_Click),
    .o_Long_Press  (o_Long_Press),
    .o_Held        (o_Held)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Model: gesture tracked as number of presses so far, long-press flag and the cycle
  // stamp of the last edge; timeouts are elapsed-cycle comparisons against the limits.
  int   m_cyc = 0;
  int   m_since = 0;
  int   m_presses = 0;
  logic m_long = 1'b0;
  logic m_prev = 1'b0;
  logic e_press = 1'b0, e_release = 1'b0, e_single = 1'b0;
  logic e_double = 1'b0, e_long = 1'b0, e_held = 1'b0;
  logic m_rise, m_fall;
  int   m_el;

  assign m_rise = i_BTN & ~m_prev;
  assign m_fall = ~i_BTN & m_prev;
  assign m_el   = m_cyc - m_since;

  always @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      m_presses <= 0;
      m_long    <= 1'b0;
      m_prev    <= 1'b0;
      e_press   <= 1'b0;
      e_release <= 1'b0;
      e_single  <= 1'b0;
      e_double  <= 1'b0;
      e_long    <= 1'b0;
      e_held    <= 1'b0;
    end else begin
      m_cyc     <= m_cyc + 1;
      m_prev    <= i_BTN;
      e_press   <= m_rise;
      e_release <= m_fall;
      e_held    <= i_BTN;
      e_single  <= 1'b0;
      e_double  <= 1'b0;
      e_long    <= 1'b0;
      if (m_long) begin
        if (m_fall) begin
          m_long    <= 1'b0;
          m_presses <= 0;
        end
      end else if (m_presses == 0) begin
        if (m_rise) begin
          m_presses <= 1;
          m_since   <= m_cyc;
        end
      end else if (m_presses == 1 && m_prev) begin
        if (m_fall) begin
          m_since <= m_cyc;
        end else if (m_el == int'(L)) begin
          e_long <= 1'b1;
          m_long <= 1'b1;
        end
      end else if (m_presses == 1) begin
        if (m_rise) begin
          m_presses <= 2;
          m_since   <= m_cyc;
        end else if (m_el == int'(G)) begin
          e_single  <= 1'b1;
          m_presses <= 0;
        end
      end else begin
        if (m_fall) begin
          e_double  <= 1'b1;
          m_presses <= 0;
        end else if (m_el == int'(L)) begin
          e_long <= 1'b1;
          m_long <= 1'b1;
        end
      end
    end
  end

  task automatic cmp_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0b expected %0b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp_bit("press", o_Press, e_press);
      cmp_bit("release", o_Release, e_release);
      cmp_bit("single", o_Single_Click, e_single);
      cmp_bit("double", o_Double_Click, e_double);
      cmp_bit("long", o_Long_Press, e_long);
      cmp_bit("held", o_Held, e_held);
    end
  end

  // Pulse counts and last pulse times, read by the directed literal checks.
  int tb_cyc = 0;
  int c_press, c_release, c_single, c_double, c_long;
  int t_press, t_release, t_single, t_double, t_long;
  logic held_low_seen;

  always @(negedge CLK) begin
    tb_cyc <= tb_cyc + 1;
    if (o_Press)        begin c_press++;   t_press = tb_cyc;   end
    if (o_Release)      begin c_release++; t_release = tb_cyc; end
    if (o_Single_Click) begin c_single++;  t_single = tb_cyc;  end
    if (o_Double_Click) begin c_double++;  t_double = tb_cyc;  end
    if (o_Long_Press)   begin c_long++;    t_long = tb_cyc;    end
  end

  task automatic clr();
    c_press = 0; c_release = 0; c_single = 0; c_double = 0; c_long = 0;
    t_press = 0; t_release = 0; t_single = 0; t_double = 0; t_long = 0;
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) begin
      i_BTN = b;
      @(negedge CLK);
    end
  endtask

  initial begin
    clr();
    #1 i_Rst_L = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    // 1. Reset with the button toggling, then release with the button low.
    for (int i = 0; i < 6; i++) hold(i[0], 1);
    hold(1'b0, 1);
    i_Rst_L = 1'b1;
    hold(1'b0, 5);
    cmp_int("reset_no_press", c_press, 0);
    cmp_int("reset_no_release", c_release, 0);

    // 2. Single click.
    clr();
    hold(1'b1, 5);
    hold(1'b0, 15);
    cmp_int("sc_press", c_press, 1);
    cmp_int("sc_release", c_release, 1);
    cmp_int("sc_single", c_single, 1);
    cmp_int("sc_gap", t_single - t_release, 10);
    cmp_int("sc_double", c_double, 0);
    cmp_int("sc_long", c_long, 0);

    // 3. Double click.
    clr();
    hold(1'b1, 5); hold(1'b0, 4); hold(1'b1, 5); hold(1'b0, 15);
    cmp_int("dc_press", c_press, 2);
    cmp_int("dc_release", c_release, 2);
    cmp_int("dc_double", c_double, 1);
    cmp_int("dc_coincident", t_double, t_release);
    cmp_int("dc_single", c_single, 0);

    // 4. Long press.
    clr();
    held_low_seen = 1'b0;
    hold(1'b1, 30);
    cmp_int("lp_count", c_long, 1);
    cmp_int("lp_delay", t_long - t_press, 20);
    hold(1'b0, 16);
    cmp_int("lp_release", c_release, 1);
    cmp_int("lp_no_click", c_single + c_double, 0);

    // 5a. Second press lands on the timeout edge: double click.
    clr();
    hold(1'b1, 3); hold(1'b0, 10); hold(1'b1, 3); hold(1'b0, 15);
    cmp_int("gap_edge_double", c_double, 1);
    cmp_int("gap_edge_single", c_single, 0);

    // 5b. One cycle later: single click, then a fresh gesture that ends as another single.
    clr();
    hold(1'b1, 3); hold(1'b0, 11); hold(1'b1, 3); hold(1'b0, 15);
    cmp_int("gap_late_single", c_single, 2);
    cmp_int("gap_late_double", c_double, 0);
    cmp_int("gap_late_press", c_press, 2);

    // 6. Reset in the gap window abandons the click.
    clr();
    hold(1'b1, 3); hold(1'b0, 3);
    i_Rst_L = 1'b0;
    hold(1'b0, 2);
    i_Rst_L = 1'b1;
    hold(1'b0, 15);
    cmp_int("rst_gap_single", c_single, 0);
    hold(1'b1, 4); hold(1'b0, 15);
    cmp_int("rst_fresh_single", c_single, 1);

    // Random traffic, lengths biased toward the limits.
    for (int s = 0; s < 400; s++) begin
      int len;
      case ($urandom_range(0, 3))
        0: len = int'(G) - 1 + int'($urandom_range(0, 2));
        1: len = int'(L) - 1 + int'($urandom_range(0, 2));
        default: len = int'($urandom_range(1, 25));
      endcase
      hold(s[0] ? 1'b0 : 1'b1, len);
      if ($urandom_range(0, 39) == 0) begin
        i_Rst_L = 1'b0;
        hold($urandom_range(0, 1) == 1, 2);
        i_Rst_L = 1'b1;
      end
    end
    hold(1'b0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
